// File: rtl/rr_mux41_stream.sv
// rr_mux41_stream: 4:1 round-robin valid/ready stream merger with packet lock and source tag
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_in_valid[3:0]     per-channel beat valid
//   i_in_data[4*W-1:0]  channel i data at [i*W +: W]
//   i_in_last[3:0]      per-channel end-of-packet
//   o_in_ready[3:0]     per-channel accept (combinational)
//   o_out_valid/data/sel/last  registered output beat, sel = source channel
//   i_out_ready         downstream accept
module rr_mux41_stream #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_in_valid,
  input  logic [4*WIDTH-1:0] i_in_data,
  input  logic [3:0]         i_in_last,
  output logic [3:0]         o_in_ready,
  output logic               o_out_valid,
  output logic [WIDTH-1:0]   o_out_data,
  output logic [1:0]         o_out_sel,
  output logic               o_out_last,
  input  logic               i_out_ready
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_lock;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic             r_last;
  logic             w_load;
  logic [7:0]       w_dbl;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_gnt;
  logic             w_has;
  logic             w_acc;
  always_comb begin
    w_load = !r_valid || i_out_ready;
    // rotate requests so bit 0 is the channel at r_ptr, then pick the first set bit
    w_dbl = {i_in_valid, i_in_valid} >> r_ptr;
    w_rot = w_dbl[3:0];
    w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    w_gnt = (r_state == LOCK) ? r_lock : r_ptr + w_off;
    w_has = (r_state == LOCK) || (|i_in_valid);
    o_in_ready = (!i_rst && w_load && w_has) ? 4'b0001 << w_gnt : 4'b0000;
    w_acc = |(o_in_ready & i_in_valid);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_lock  <= 2'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_last  <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= i_in_data[w_gnt*WIDTH +: WIDTH];
      r_sel   <= w_gnt;
      r_last  <= i_in_last[w_gnt];
      if (i_in_last[w_gnt]) begin
        r_state <= IDLE;
        r_ptr   <= w_gnt + 2'd1;
      end else begin
        r_state <= LOCK;
        r_lock  <= w_gnt;
      end
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_sel   = r_sel;
  assign o_out_last  = r_last;
endmodule

// File: tb/tb_rr_mux41_stream.sv
// tb_rr_mux41_stream: directed stimulus with scoreboard queue and output monitor
module tb_rr_mux41_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = 4'b0;
  logic [31:0] in_data = 32'h13121110;
  logic [3:0]  in_last = 4'b1111;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;
  logic        out_ready = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [10:0] q[$];
  logic [10:0] got;
  logic [10:0] exp_beat;
  rr_mux41_stream #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
    .i_in_last(in_last), .o_in_ready(in_ready), .o_out_valid(out_valid),
    .o_out_data(out_data), .o_out_sel(out_sel), .o_out_last(out_last),
    .i_out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int c, input logic [7:0] d, input logic l);
    in_data[c*8 +: 8] = d;
    in_last[c] = l;
  endtask
  task automatic push(input logic [1:0] s, input logic [7:0] d, input logic l);
    q.push_back({s, d, l});
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got = {out_sel, out_data, out_last};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got sel=%0d data=%0h last=%0b, expected none", out_sel, out_data, out_last);
      end else begin
        exp_beat = q.pop_front();
        if (got !== exp_beat) begin
          errors++;
          $display("FAIL beat: got sel=%0d data=%0h last=%0b expected sel=%0d data=%0h last=%0b",
                   got[10:9], got[8:1], got[0], exp_beat[10:9], exp_beat[8:1], exp_beat[0]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    in_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 4'b0000;
    rst = 1'b0;
    step();
    // single beat on ch2
    set_ch(2, 8'hA5, 1'b1);
    in_valid = 4'b0100;
    #1 chk("t1_in_ready", in_ready, 4'b0100);
    push(2, 8'hA5, 1);
    step();
    in_valid = 4'b0000;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_sel", out_sel, 2);
    // wrap: rr_ptr=3, ch0 and ch3 valid -> ch3 then ch0
    set_ch(2, 8'h12, 1'b1);
    in_valid = 4'b1001;
    #1 chk("t5_first_ready", in_ready, 4'b1000);
    push(3, 8'h13, 1);
    step();
    chk("t5_second_ready", in_ready, 4'b0001);
    push(0, 8'h10, 1);
    step();
    in_valid = 4'b0000;
    // fairness from rr_ptr=1, no bubbles
    in_valid = 4'b1111;
    push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1); push(0, 8'h10, 1);
    push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1); push(0, 8'h10, 1);
    repeat (8) step();
    in_valid = 4'b0000;
    step();
    chk("t2_drained", q.size(), 0);
    // packet lock on ch1, with a gap where ch1 drops valid
    in_valid = 4'b1111;
    set_ch(1, 8'h31, 1'b0);
    push(1, 8'h31, 0);
    step();
    in_valid = 4'b1101;
    #1 chk("t3_lock_gap_ready", in_ready, 4'b0010);
    step();
    in_valid = 4'b1111;
    set_ch(1, 8'h32, 1'b0);
    push(1, 8'h32, 0);
    step();
    set_ch(1, 8'h33, 1'b1);
    push(1, 8'h33, 1);
    step();
    chk("t3_next_ready", in_ready, 4'b0100);
    push(2, 8'h12, 1);
    step();
    in_valid = 4'b0000;
    set_ch(1, 8'h11, 1'b1);
    step();
    // backpressure on ch3 (rr_ptr=3)
    set_ch(3, 8'hC3, 1'b1);
    in_valid = 4'b1000;
    push(3, 8'hC3, 1);
    step();
    out_ready = 1'b0;
    set_ch(3, 8'hC4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stall_ready", in_ready, 0);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_data", out_data, 8'hC3);
      chk("t4_stall_sel", out_sel, 3);
      step();
    end
    out_ready = 1'b1;
    #1 chk("t4_release_ready", in_ready, 4'b1000);
    push(3, 8'hC4, 1);
    step();
    in_valid = 4'b0000;
    step();
    // reset during LOCK on ch2 with a held beat (rr_ptr=0)
    out_ready = 1'b0;
    set_ch(2, 8'h66, 1'b0);
    in_valid = 4'b0100;
    step();
    chk("t6_held_valid", out_valid, 1);
    rst = 1'b1;
    #1 chk("t6_rst_ready", in_ready, 0);
    step();
    chk("t6_after_rst_valid", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    set_ch(2, 8'h12, 1'b1);
    in_valid = 4'b0110;
    #1 chk("t6_first_ready", in_ready, 4'b0010);
    push(1, 8'h11, 1);
    step();
    push(2, 8'h12, 1);
    step();
    in_valid = 4'b0000;
    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
